column_scheduler: RTL and testbench

COLUMN_SCHEDULER -- requirements
Module: column_scheduler

---
 rtl/column_scheduler.sv | 99 +++++++++
 tb/tb_column_scheduler.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/column_scheduler.sv
// column_scheduler: per-window peak detector feeding a one-entry pending slot and a draw request handshake
module column_scheduler #(
  parameter int SAMPLE_W        = 24,
  parameter int CLKS_PER_COLUMN = 5000000,
  parameter int HEIGHT_SHIFT    = 14,
  parameter int HEIGHT_MAX      = 400
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enable,
  input  logic                       sample_valid,
  input  logic signed [SAMPLE_W-1:0] sample,
  input  logic                       draw_done,
  output logic                       draw_start,
  output logic [8:0]                 bar_height,
  output logic                       busy,
  output logic [7:0]                 overrun_cnt
);
  localparam int CW = CLKS_PER_COLUMN > 1 ? $clog2(CLKS_PER_COLUMN) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_COLUMN - 1);
  typedef enum logic {IDLE, RUN} acc_t;
  typedef enum logic [1:0] {READY, START, WAIT} hs_t;
  acc_t r_acc, w_acc_nxt;
  hs_t r_hs, w_hs_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [SAMPLE_W-1:0] r_peak, w_peak_nxt, w_mag, w_col, w_shift;
  logic [8:0] r_pend, w_pend_nxt, r_bar, w_bar_nxt, w_height;
  logic [7:0] r_ovr, w_ovr_nxt;
  logic r_pv, w_pv_nxt, r_done_q, w_end, w_xfer;
  // the most negative sample has no positive twin, so it clamps to full scale
  assign w_mag = !sample[SAMPLE_W-1] ? sample :
                 ~|sample[SAMPLE_W-2:0] ? {1'b0, {(SAMPLE_W-1){1'b1}}} : -sample;
  assign w_col = (sample_valid && w_mag > r_peak) ? w_mag : r_peak;
  assign w_shift = w_col >> HEIGHT_SHIFT;
  assign w_height = (w_shift > SAMPLE_W'(HEIGHT_MAX)) ? 9'(HEIGHT_MAX) : w_shift[8:0];
  assign w_end = r_acc == RUN && enable && r_cnt == LAST;
  assign w_xfer = r_hs == READY && r_pv;
  always_comb begin
    w_acc_nxt = r_acc;
    w_cnt_nxt = '0;
    w_peak_nxt = '0;
    w_pend_nxt = r_pend;
    w_pv_nxt = r_pv && !w_xfer;
    w_ovr_nxt = r_ovr;
    if (r_acc == IDLE) w_acc_nxt = enable ? RUN : IDLE;
    else if (!enable) begin
      w_acc_nxt = IDLE;
      w_pv_nxt = 1'b0;
    end else begin
      w_cnt_nxt = w_end ? '0 : r_cnt + 1'b1;
      w_peak_nxt = w_end ? '0 : w_col;
      if (w_end) begin
        w_pend_nxt = w_height;
        w_pv_nxt = 1'b1;
        w_ovr_nxt = r_ovr + {7'd0, r_pv && !w_xfer && r_ovr != 8'hFF};
      end
    end
  end
  always_comb begin
    w_hs_nxt = r_hs;
    w_bar_nxt = r_bar;
    case (r_hs)
      READY: begin
        w_hs_nxt = r_pv ? START : READY;
        w_bar_nxt = r_pv ? r_pend : r_bar;
      end
      START: w_hs_nxt = WAIT;
      WAIT: w_hs_nxt = (draw_done && !r_done_q) ? READY : WAIT;
      default: w_hs_nxt = READY;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_acc <= IDLE;
      r_hs <= READY;
      r_cnt <= '0;
      r_peak <= '0;
      r_pend <= '0;
      r_pv <= 1'b0;
      r_ovr <= '0;
      r_bar <= '0;
      r_done_q <= 1'b0;
    end else begin
      r_acc <= w_acc_nxt;
      r_hs <= w_hs_nxt;
      r_cnt <= w_cnt_nxt;
      r_peak <= w_peak_nxt;
      r_pend <= w_pend_nxt;
      r_pv <= w_pv_nxt;
      r_ovr <= w_ovr_nxt;
      r_bar <= w_bar_nxt;
      r_done_q <= draw_done;
    end
  end
  assign draw_start = r_hs == START;
  assign busy = r_hs != READY;
  assign bar_height = r_bar;
  assign overrun_cnt = r_ovr;
endmodule

// File: tb/tb_column_scheduler.sv
// tb_column_scheduler: directed scenarios for column_scheduler with a 100-cycle window
module tb_column_scheduler;
  logic clk = 1'b0, reset = 1'b1, enable = 1'b0, sample_valid = 1'b0, draw_done = 1'b0;
  logic [23:0] sample = '0;
  logic draw_start, busy;
  logic [8:0] bar_height;
  logic [7:0] overrun_cnt;
  int errors = 0, checks = 0, ds_cnt = 0;
  column_scheduler #(.SAMPLE_W(24), .CLKS_PER_COLUMN(100), .HEIGHT_SHIFT(14), .HEIGHT_MAX(400)) dut (
    .clk(clk), .reset(reset), .enable(enable), .sample_valid(sample_valid), .sample(sample),
    .draw_done(draw_done), .draw_start(draw_start), .bar_height(bar_height), .busy(busy),
    .overrun_cnt(overrun_cnt));
  always #5 clk = ~clk;
  task tick();
    @(posedge clk);
    #1;
    if (draw_start) ds_cnt++;
  endtask
  task ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask
  task pulse(input logic [23:0] s);
    sample = s;
    sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
  endtask
  task wait_ds(input int max, output int t);
    t = -1;
    for (int i = 1; i <= max; i++) begin
      tick();
      if (draw_start) begin
        t = i;
        break;
      end
    end
  endtask
  task do_reset();
    reset = 1'b1; enable = 1'b0; sample_valid = 1'b0; sample = '0; draw_done = 1'b0;
    ticks(2);
    reset = 1'b0;
    ds_cnt = 0;
  endtask
  task test_reset();
    reset = 1'b1; enable = 1'b1; draw_done = 1'b1;
    ticks(3);
    checks++; if (draw_start !== 1'b0) begin errors++; $display("FAIL reset_start got %0d want 0", draw_start); end
    checks++; if (bar_height !== 9'd0) begin errors++; $display("FAIL reset_bar got %0d want 0", bar_height); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0d want 0", busy); end
    checks++; if (overrun_cnt !== 8'd0) begin errors++; $display("FAIL reset_ovr got %0d want 0", overrun_cnt); end
  endtask
  task test_latency();
    int t;
    do_reset();
    draw_done = 1'b1; enable = 1'b1;
    ticks(50);
    pulse(24'h200000);
    wait_ds(200, t);
    checks++; if (t !== 51) begin errors++; $display("FAIL latency_cycles got %0d want 51", t); end
    checks++; if (bar_height !== 9'd128) begin errors++; $display("FAIL latency_bar got %0d want 128", bar_height); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL latency_busy got %0d want 1", busy); end
    draw_done = 1'b0;
    tick();
    checks++; if (draw_start !== 1'b0) begin errors++; $display("FAIL start_one_cycle got %0d want 0", draw_start); end
    ticks(9);
    draw_done = 1'b1;
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL latency_done got busy %0d want 0", busy); end
    checks++; if (ds_cnt !== 1) begin errors++; $display("FAIL latency_count got %0d want 1", ds_cnt); end
  endtask
  task test_saturate();
    int t;
    do_reset();
    draw_done = 1'b1; enable = 1'b1;
    ticks(10);
    pulse(24'h800000);
    wait_ds(200, t);
    checks++; if (t !== 91) begin errors++; $display("FAIL sat_cycles got %0d want 91", t); end
    checks++; if (bar_height !== 9'd400) begin errors++; $display("FAIL sat_bar got %0d want 400", bar_height); end
  endtask
  task test_window_end_sample();
    int t;
    do_reset();
    draw_done = 1'b1; enable = 1'b1;
    ticks(100);
    pulse(24'hE80000);
    wait_ds(10, t);
    checks++; if (t !== 1) begin errors++; $display("FAIL wend_cycles got %0d want 1", t); end
    checks++; if (bar_height !== 9'd96) begin errors++; $display("FAIL wend_bar got %0d want 96", bar_height); end
  endtask
  task test_overrun();
    int t;
    do_reset();
    draw_done = 1'b0; enable = 1'b1;
    ticks(49); pulse(24'h040000);
    ticks(99); pulse(24'h080000);
    ticks(99); pulse(24'h0C0000);
    ticks(60);
    checks++; if (ds_cnt !== 1) begin errors++; $display("FAIL ovr_starts got %0d want 1", ds_cnt); end
    checks++; if (overrun_cnt !== 8'd1) begin errors++; $display("FAIL ovr_cnt got %0d want 1", overrun_cnt); end
    checks++; if (bar_height !== 9'd16) begin errors++; $display("FAIL ovr_bar_stable got %0d want 16", bar_height); end
    draw_done = 1'b1;
    wait_ds(10, t);
    checks++; if (t !== 2) begin errors++; $display("FAIL ovr_reissue got %0d want 2", t); end
    checks++; if (bar_height !== 9'd48) begin errors++; $display("FAIL ovr_bar got %0d want 48", bar_height); end
    checks++; if (overrun_cnt !== 8'd1) begin errors++; $display("FAIL ovr_cnt_after got %0d want 1", overrun_cnt); end
  endtask
  task test_done_held_high();
    int t;
    do_reset();
    draw_done = 1'b1; enable = 1'b1;
    ticks(50);
    pulse(24'h200000);
    wait_ds(200, t);
    checks++; if (t !== 51) begin errors++; $display("FAIL high_cycles got %0d want 51", t); end
    ticks(20);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL high_no_complete got busy %0d want 1", busy); end
    draw_done = 1'b0;
    tick();
    draw_done = 1'b1;
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL high_complete got busy %0d want 0", busy); end
    checks++; if (ds_cnt !== 1) begin errors++; $display("FAIL high_starts got %0d want 1", ds_cnt); end
  endtask
  task test_enable_drop();
    int t;
    do_reset();
    draw_done = 1'b0; enable = 1'b1;
    ticks(102);
    checks++; if (draw_start !== 1'b1) begin errors++; $display("FAIL drop_first got %0d want 1", draw_start); end
    ticks(150);
    enable = 1'b0;
    ticks(10);
    draw_done = 1'b1;
    ticks(150);
    checks++; if (ds_cnt !== 1) begin errors++; $display("FAIL drop_starts got %0d want 1", ds_cnt); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL drop_busy got %0d want 0", busy); end
    pulse(24'h3FFFFF);
    enable = 1'b1;
    wait_ds(200, t);
    checks++; if (t !== 102) begin errors++; $display("FAIL reenable_cycles got %0d want 102", t); end
    checks++; if (bar_height !== 9'd0) begin errors++; $display("FAIL idle_sample_bar got %0d want 0", bar_height); end
  endtask
  task test_reset_wait();
    int t;
    do_reset();
    draw_done = 1'b0; enable = 1'b1;
    ticks(50);
    pulse(24'h200000);
    ticks(60);
    checks++; if (bar_height !== 9'd128 || busy !== 1'b1) begin errors++; $display("FAIL rw_pre got bar %0d busy %0d want 128 1", bar_height, busy); end
    reset = 1'b1;
    tick();
    checks++; if (draw_start !== 1'b0 || bar_height !== 9'd0 || busy !== 1'b0 || overrun_cnt !== 8'd0) begin
      errors++; $display("FAIL rw_reset got start %0d bar %0d busy %0d ovr %0d want 0 0 0 0", draw_start, bar_height, busy, overrun_cnt);
    end
    reset = 1'b0;
    ds_cnt = 0;
    wait_ds(200, t);
    checks++; if (t !== 102) begin errors++; $display("FAIL rw_restart got %0d want 102", t); end
    checks++; if (bar_height !== 9'd0) begin errors++; $display("FAIL rw_bar got %0d want 0", bar_height); end
  endtask
  initial begin
    test_reset();
    test_latency();
    test_saturate();
    test_window_end_sample();
    test_overrun();
    test_done_held_high();
    test_enable_drop();
    test_reset_wait();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
